alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Initiator side of the calculator ALU interface. Takes one operation request from the keypad/UI front end over a valid/ready handshake and drives one-hot op, data1 and data2 into the ALU.
- Sequences the ALU's single-cycle (add/sub) and multi-cycle busy-handshaked (mul) protocols, captures the 8-bit ALU result and returns it over a valid/ready response channel.
- Guards against an unsupported op (divide) and against an ALU that never completes (timeout).

Parameters:
- TIMEOUT, 32: maximum cycles spent in any busy-wait state before aborting with error.
- CW, 6: width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div
- req_a  in  4  operand A, two's complement
- req_b  in  4  operand B, two's complement
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  8  captured ALU result (raw alu_o)
- rsp_err  out  1  1 = unsupported op or timeout; rsp_result is then 0
- alu_op  out  4  one-hot ALU op: 1000 add, 0100 sub, 0010 mul, 0000 STOP
- alu_data1  out  4  ALU operand 1
- alu_data2  out  4  ALU operand 2
- alu_o  in  8  ALU result
- alu_busy  in  1  ALU multi-cycle busy

Behaviour:
- All outputs are registered.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0.
  - alu_op=0000, alu_data1=0, alu_data2=0.
  - State=IDLE, timeout counter=0.
  - req_ready rises the cycle after rst deasserts.
- Reset mid-operation: return to IDLE, alu_op=STOP, any pending response discarded.
- Request handshake:
  - A request is accepted on an edge with req_valid && req_ready.
  - req_ready=1 only in IDLE; it drops to 0 in the cycle after acceptance.
  - req_a/req_b are latched into alu_data1/alu_data2 at acceptance and held until the next accept.
- States:
  - IDLE: alu_op=STOP. On accept:
    - div → RESP with err=1.
    - Otherwise → ISSUE, with alu_op set to the one-hot code on the same edge.
  - ISSUE: one cycle with alu_op driven. Add/sub → CAPT; mul → WAIT_HI. Counter cleared.
  - CAPT (add/sub): alu_op=STOP. Capture alu_o into rsp_result at end of cycle → RESP.
  - WAIT_HI (mul): hold alu_op=0010. alu_busy=1 → WAIT_LO; counter==TIMEOUT → ABORT.
  - WAIT_LO: hold alu_op=0010. On the first cycle alu_busy=0:
    - Capture alu_o.
    - Go to RETIRE.
    - Counter==TIMEOUT → ABORT.
  - RETIRE: hold alu_op=0010 for exactly one cycle, which lets the ALU step counter return to its start state → RESP with alu_op=STOP.
  - ABORT: alu_op=STOP, rsp_result=0, err=1 → RESP.
  - RESP: rsp_valid=1. rsp_result/rsp_err are stable while rsp_valid && !rsp_ready. On rsp_valid && rsp_ready → IDLE, rsp_valid=0.
- Timing:
  - ISSUE begins the cycle after accept.
  - Add/sub: rsp_valid is asserted 3 cycles after the accept edge.
  - Mul with an ALU whose busy is high for 9 cycles: rsp_valid is asserted 13 cycles after accept.
- Busy handling:
  - alu_busy is ignored in ISSUE; the ALU's busy flag lags op by one edge.
  - An alu_busy pulse while IDLE/CAPT/RESP is ignored.
- Counter: increments every cycle in WAIT_HI/WAIT_LO and saturates at TIMEOUT.
- No new request is accepted until the response has been taken; at most one operation is in flight.

Test Plan:
- Add: req op=00 a=3 b=4; bench ALU model returns alu_o=8'h07 one edge after alu_op=1000 → rsp_result=8'h07, err=0, rsp_valid 3 cycles after accept; alu_op sequence IDLE 0000, 1000 for one cycle, then 0000.
- Sub with backpressure: op=01 a=2 b=5, model alu_o=8'h1D, rsp_ready held 0 for 4 cycles → rsp_valid held, result 8'h1D stable, req_ready=0 throughout; returns to IDLE the cycle after rsp_ready=1.
- Mul: op=10 a=3 b=-2 (4'hE), model asserts busy 9 cycles then drops with alu_o=8'hFA → alu_op=0010 held through RETIRE then 0000; rsp_result=8'hFA, err=0, rsp_valid 13 cycles after accept.
- Div: op=11 a=6 b=2 → alu_op stays 0000, rsp_valid the cycle after accept, rsp_err=1, rsp_result=0.
- Timeout: op=10 with a model that never raises busy → ABORT after TIMEOUT cycles in WAIT_HI, rsp_err=1; repeat with busy stuck high → abort from WAIT_LO.
- Reset mid-mul: assert rst during WAIT_LO → next cycle alu_op=0000, rsp_valid=0, req_ready=0; req_ready=1 one cycle after rst release; a following add completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Initiator side of the calculator ALU interface. Accepts one operation
//   request over a valid/ready handshake, drives a one-hot op and the two
//   operands into the ALU, follows either the single-cycle (add/sub) or the
//   busy-handshaked multi-cycle (mul) protocol, and returns the captured
//   8-bit ALU result over a valid/ready response channel. Divide is rejected
//   and a busy-wait that exceeds TIMEOUT cycles is aborted; both report
//   rsp_err=1 with rsp_result=0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_op              00 add, 01 sub, 10 mul, 11 div
//   req_a, req_b        4-bit two's complement operands
//   rsp_valid/rsp_ready response handshake
//   rsp_result          raw ALU result (0 on error)
//   rsp_err             unsupported op or timeout
//   alu_op              one-hot op: 1000 add, 0100 sub, 0010 mul, 0000 STOP
//   alu_data1/2         ALU operands
//   alu_o, alu_busy     ALU result and multi-cycle busy flag
//
// Parameters
//   TIMEOUT  maximum cycles in any busy-wait state before aborting
//   CW       timeout counter width, 2**CW > TIMEOUT
module alu_sequencer #(
    parameter int TIMEOUT = 32,
    parameter int CW      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_err,
    output logic [3:0] alu_op,
    output logic [3:0] alu_data1,
    output logic [3:0] alu_data2,
    input  logic [7:0] alu_o,
    input  logic       alu_busy
);

    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    localparam logic [3:0] ALU_STOP = 4'b0000;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPT,
        WAIT_HI,
        WAIT_LO,
        RETIRE,
        ABORT,
        RESP
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    op_q;
    logic [1:0]    op_sel;
    logic          accept;
    logic          capture;
    logic [3:0]    alu_op_nx;

    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        case (op)
            2'b00:   op_onehot = 4'b1000;
            2'b01:   op_onehot = 4'b0100;
            2'b10:   op_onehot = 4'b0010;
            default: op_onehot = 4'b0000;
        endcase
    endfunction

    // req_ready is only ever high in IDLE, so accept implies state == IDLE.
    assign accept = req_valid && req_ready;
    assign op_sel = accept ? req_op : op_q;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        capture   = 1'b0;
        alu_op_nx = ALU_STOP;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (req_op == OP_DIV) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                // alu_busy lags alu_op by one edge, so it is not looked at here.
                cnt_nx   = '0;
                state_nx = (op_q == OP_MUL) ? WAIT_HI : CAPT;
            end
            CAPT: begin
                capture  = 1'b1;
                state_nx = RESP;
            end
            WAIT_HI: begin
                if (alu_busy) begin
                    // Each busy-wait state gets its own TIMEOUT budget.
                    state_nx = WAIT_LO;
                    cnt_nx   = '0;
                end else if (cnt == TMO) begin
                    state_nx = ABORT;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            WAIT_LO: begin
                if (!alu_busy) begin
                    capture  = 1'b1;
                    state_nx = RETIRE;
                end else if (cnt == TMO) begin
                    state_nx = ABORT;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RETIRE: state_nx = RESP;
            ABORT:  state_nx = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        case (state_nx)
            ISSUE:                   alu_op_nx = op_onehot(op_sel);
            WAIT_HI, WAIT_LO, RETIRE: alu_op_nx = ALU_MUL;
            default:                 alu_op_nx = ALU_STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            alu_op     <= ALU_STOP;
            alu_data1  <= '0;
            alu_data2  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            req_ready <= (state_nx == IDLE);
            rsp_valid <= (state_nx == RESP);
            alu_op    <= alu_op_nx;

            if (accept) begin
                op_q       <= req_op;
                alu_data1  <= req_a;
                alu_data2  <= req_b;
                rsp_result <= '0;
                rsp_err    <= (req_op == OP_DIV);
            end

            if (capture) begin
                rsp_result <= alu_o;
            end

            if (state_nx == ABORT) begin
                rsp_result <= '0;
                rsp_err    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: constant vector table, hand-written corner
// sequences and randomized operations against a behavioural reference.
module tb_alu_sequencer;

    localparam int TIMEOUT = 32;
    localparam int CW      = 6;

    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STUCK  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_err;
    logic [3:0] alu_op;
    logic [3:0] alu_data1;
    logic [3:0] alu_data2;
    logic [7:0] alu_o = 8'h00;
    logic       alu_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    int         mode = M_NORMAL;
    int         busy_len = 9;
    logic       ovr_en = 1'b0;
    logic [7:0] ovr_val = 8'h00;
    logic [3:0] op_trace[$];

    alu_sequencer #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_o(alu_o), .alu_busy(alu_busy)
    );

    always #5 clk = ~clk;

    // ALU environment: add/sub answer one edge after the op is seen; mul
    // raises busy one edge after the op and holds it for busy_len cycles.
    logic mul_active = 1'b0;
    logic mul_done   = 1'b0;
    int   steps      = 0;

    always @(posedge clk) begin
        case (alu_op)
            4'b1000: alu_o <= ovr_en ? ovr_val
                                     : 8'($signed(alu_data1) + $signed(alu_data2));
            4'b0100: alu_o <= ovr_en ? ovr_val
                                     : 8'($signed(alu_data1) - $signed(alu_data2));
            4'b0010: begin
                if (mode == M_NORMAL) begin
                    if (!mul_active && !mul_done) begin
                        mul_active <= 1'b1;
                        alu_busy   <= 1'b1;
                        steps      <= busy_len - 1;
                    end else if (mul_active) begin
                        if (steps == 0) begin
                            alu_busy   <= 1'b0;
                            mul_active <= 1'b0;
                            mul_done   <= 1'b1;
                            alu_o      <= 8'($signed(alu_data1) * $signed(alu_data2));
                        end else begin
                            steps <= steps - 1;
                        end
                    end
                end
            end
            default: begin
                mul_active <= 1'b0;
                mul_done   <= 1'b0;
                alu_busy   <= 1'b0;
            end
        endcase
        if (mode == M_STUCK) alu_busy <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: result, error flag and cycles from the accept edge until
    // rsp_valid is seen, computed directly from the operation's rules.
    function automatic void ref_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                   input int blen, output logic [7:0] r, output logic e,
                                   output int lat);
        int sa = $signed(a);
        int sb = $signed(b);
        e = 1'b0;
        case (op)
            2'b00: begin r = 8'(sa + sb); lat = 3; end
            2'b01: begin r = 8'(sa - sb); lat = 3; end
            2'b10: begin r = 8'(sa * sb); lat = blen + 4; end
            default: begin r = 8'h00; e = 1'b1; lat = 1; end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input int hold, output logic [7:0] res, output logic err,
                          output int lat);
        int w = 0;
        while (!req_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        op_trace.delete();
        chk("req_ready_drop", {31'b0, req_ready}, 32'd0);
        chk("alu_data1", {28'b0, alu_data1}, {28'b0, a});
        chk("alu_data2", {28'b0, alu_data2}, {28'b0, b});
        op_trace.push_back(alu_op);
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
            op_trace.push_back(alu_op);
        end
        chk("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
        res = rsp_result;
        err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_result", {24'b0, rsp_result}, {24'b0, res});
            chk("hold_err", {31'b0, rsp_err}, {31'b0, err});
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_clear", {31'b0, rsp_valid}, 32'd0);
        chk("req_ready_back", {31'b0, req_ready}, 32'd1);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        int         blen;
        int         hold;
        logic [7:0] exp_r;
        logic       exp_e;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r, er;
        logic       e, ee;
        int         lat, elat;
        logic [1:0] rop;
        logic [3:0] ra, rb;
        int         rbl, rh;

        vecs[0] = '{2'b00, 4'h3, 4'h4, 1, 0, 8'h07, 1'b0, 3};
        vecs[1] = '{2'b00, 4'h7, 4'h7, 1, 1, 8'h0E, 1'b0, 3};
        vecs[2] = '{2'b00, 4'h8, 4'h8, 1, 0, 8'hF0, 1'b0, 3};
        vecs[3] = '{2'b01, 4'h8, 4'h1, 1, 2, 8'hF7, 1'b0, 3};
        vecs[4] = '{2'b10, 4'h7, 4'h7, 3, 0, 8'h31, 1'b0, 7};
        vecs[5] = '{2'b10, 4'h8, 4'h8, 1, 1, 8'h40, 1'b0, 5};
        vecs[6] = '{2'b10, 4'h8, 4'h7, 12, 0, 8'hC8, 1'b0, 16};
        vecs[7] = '{2'b11, 4'h6, 4'h2, 1, 0, 8'h00, 1'b1, 1};

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 2'b00; req_a = 4'h0; req_b = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", {24'b0, rsp_result}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
        chk("rst_alu_data", {24'b0, alu_data1, alu_data2}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("req_ready_after_rst", {31'b0, req_ready}, 32'd1);

        // Add with op trace: 1000 for one cycle then STOP
        run_op(2'b00, 4'h3, 4'h4, 0, r, e, lat);
        chk("add_result", {24'b0, r}, 32'h07);
        chk("add_err", {31'b0, e}, 32'd0);
        chk("add_lat", lat, 3);
        chk("add_op_issue", {28'b0, op_trace[0]}, 32'b1000);
        chk("add_op_capt", {28'b0, op_trace[1]}, 32'b0000);

        // Sub with backpressure and a fixed ALU answer
        ovr_en = 1'b1; ovr_val = 8'h1D;
        run_op(2'b01, 4'h2, 4'h5, 4, r, e, lat);
        ovr_en = 1'b0;
        chk("sub_result", {24'b0, r}, 32'h1D);
        chk("sub_err", {31'b0, e}, 32'd0);
        chk("sub_lat", lat, 3);

        // Mul 3 * -2 with 9 busy cycles
        busy_len = 9;
        run_op(2'b10, 4'h3, 4'hE, 0, r, e, lat);
        chk("mul_result", {24'b0, r}, 32'hFA);
        chk("mul_err", {31'b0, e}, 32'd0);
        chk("mul_lat", lat, 13);
        chk("mul_op_issue", {28'b0, op_trace[0]}, 32'b0010);
        chk("mul_op_retire", {28'b0, op_trace[11]}, 32'b0010);
        chk("mul_op_resp", {28'b0, op_trace[12]}, 32'b0000);

        // Divide is rejected immediately
        run_op(2'b11, 4'h6, 4'h2, 0, r, e, lat);
        chk("div_result", {24'b0, r}, 32'h00);
        chk("div_err", {31'b0, e}, 32'd1);
        chk("div_lat", lat, 1);
        chk("div_op", {28'b0, op_trace[0]}, 32'b0000);

        // Timeout waiting for busy to rise
        mode = M_NEVER;
        run_op(2'b10, 4'h3, 4'h4, 0, r, e, lat);
        chk("to_hi_err", {31'b0, e}, 32'd1);
        chk("to_hi_result", {24'b0, r}, 32'h00);
        chk("to_hi_lat_range", {31'b0, (lat >= TIMEOUT + 3 && lat <= TIMEOUT + 6)}, 32'd1);

        // Timeout waiting for busy to fall
        mode = M_STUCK;
        run_op(2'b10, 4'h5, 4'h2, 1, r, e, lat);
        chk("to_lo_err", {31'b0, e}, 32'd1);
        chk("to_lo_result", {24'b0, r}, 32'h00);
        chk("to_lo_lat_range", {31'b0, (lat >= TIMEOUT + 3 && lat <= TIMEOUT + 6)}, 32'd1);
        mode = M_NORMAL;
        @(posedge clk); #1;

        // Reset in the middle of a multiply
        busy_len = 20;
        req_valid = 1'b1; req_op = 2'b10; req_a = 4'h3; req_b = 4'h5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_mul_busy", {31'b0, alu_busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_alu_op", {28'b0, alu_op}, 32'd0);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_req_ready_back", {31'b0, req_ready}, 32'd1);
        run_op(2'b00, 4'h1, 4'h2, 0, r, e, lat);
        chk("post_rst_add_result", {24'b0, r}, 32'h03);
        chk("post_rst_add_lat", lat, 3);

        // Constant vector table
        for (int i = 0; i < 8; i++) begin
            busy_len = vecs[i].blen;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, r, e, lat);
            chk($sformatf("vec%0d_result", i), {24'b0, r}, {24'b0, vecs[i].exp_r});
            chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_e});
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
        end

        // Randomized operations against the reference
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            rbl = $urandom_range(1, 12);
            rh  = $urandom_range(0, 3);
            busy_len = rbl;
            ref_op(rop, ra, rb, rbl, er, ee, elat);
            run_op(rop, ra, rb, rh, r, e, lat);
            chk($sformatf("rnd%0d_result", i), {24'b0, r}, {24'b0, er});
            chk($sformatf("rnd%0d_err", i), {31'b0, e}, {31'b0, ee});
            chk($sformatf("rnd%0d_lat", i), lat, elat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
